muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_val  input  32  operand A, taken from register-file read port 1.
REQ-007 SHALL have port rs2_val  input  32  operand B, taken from register-file read port 2.
REQ-008 SHALL have port rd_addr  input  5  destination register.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-010 SHALL have port wb_we  output  1  one-cycle register-file write-enable pulse.
REQ-011 SHALL have port wb_addr  output  5  latched rd_addr; drives register-file a3.
REQ-012 SHALL have port wb_data  output  32  result; drives register-file wd3.
REQ-013 SHALL have port illegal  output  1  high with wb_we when op is unsupported.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 In IDLE with start=1, SHALL latch op, operands and rd_addr at the edge and go to CALC, or directly to DONE for special cases.
REQ-016 SHALL stay in CALC for exactly 32 cycles, counted by a 6-bit counter, then go to DONE.
REQ-017 SHALL hold DONE for one cycle with wb_we=1, then return to IDLE.
REQ-018 Normal latency: start sampled at edge N gives wb_we high in the cycle after edge N+32; the next start is accepted at edge N+34.
REQ-019 SHALL ignore start while busy, with no effect on the operation in flight.
REQ-020 Multiply: shift-add on operand magnitudes; sign-correct the 64-bit product in DONE; MUL returns bits 31:0, MULH/MULHSU/MULHU return bits 63:32 with the signedness given by op.
REQ-021 Divide: restoring division on magnitudes; quotient takes the sign of A XOR B; remainder takes the sign of A.
REQ-022 Divide by zero SHALL bypass CALC: quotient 0xFFFFFFFF, remainder = rs1_val.
REQ-023 DIV/REM with A=0x80000000, B=0xFFFFFFFF SHALL bypass CALC: quotient 0x80000000, remainder 0.
REQ-024 For rd_addr=0, SHALL still pulse wb_we with wb_addr=0; the register file discards the write.
REQ-025 wb_we, illegal and wb_data SHALL be registered outputs.
REQ-026 wb_data and wb_addr SHALL be 0 except in DONE.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE and clear the counter and all outputs to 0, including mid-CALC.
REQ-028 No wb_we pulse SHALL follow a reset that aborts an operation.

Configuration
REQ-029 SHALL use macro MULDIV_DIV_EN to select the divide feature.
REQ-030 With MULDIV_DIV_EN defined, SHALL support all eight ops, and illegal SHALL stay 0.
REQ-031 Without MULDIV_DIV_EN, ops 1xx SHALL go IDLE->DONE with wb_data=0 and illegal=1, and the divide datapath SHALL be absent.

Structure
REQ-032 Package muldiv_pkg SHALL hold the op encodings, FSM state encoding, XLEN and the CALC iteration count (32).
REQ-033 Sub-module muldiv_divider SHALL hold the restoring-division datapath and SHALL be instantiated only under MULDIV_DIV_EN.

Verification
REQ-034 MUL 7 x -3, rd_addr=5 -> wb_we one cycle after edge N+32, wb_addr=5, wb_data=0xFFFFFFEB.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wb_data=0xFFFFFFFE; MULH of the same operands -> 0x00000000.
REQ-036 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at edge N+1, no CALC.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-038 start re-asserted during CALC, then rst raised at cycle 10 of CALC -> no wb_we pulse, IDLE and busy=0 the next cycle, and the next start is accepted normally.
REQ-039 Build without MULDIV_DIV_EN, op=DIVU -> wb_we and illegal=1 with wb_data=0 the cycle after the start edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states,
// datapath width and the CALC iteration count.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int CALC_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic a_is_signed(input op_e o);
    return (o != OP_MULHU) && (o != OP_DIVU) && (o != OP_REMU);
  endfunction

  function automatic logic b_is_signed(input op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Exposes the next-step quotient/remainder so the final step can be captured directly.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] quo, rem, dvsr;
  logic [XLEN:0]   shifted, trial;

  // The partial remainder never exceeds 2*divisor-1, so bit XLEN of trial is a true borrow.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      quo  <= quo_next;
      rem  <= rem_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with IDLE/CALC/DONE sequencing and a registered
// write-back pulse. Divide ops are built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal
);
  import muldiv_pkg::*;

  state_e            state;
  logic [5:0]        count;
  op_e               op_q, op_in;
  logic [4:0]        rd_q;
  logic              a_neg_q, b_neg_q, a_neg, b_neg;
  logic [2*XLEN-1:0] mcand, prod, prod_next, prod_signed;
  logic [XLEN-1:0]   mplr, mag_a, mag_b, result;

  always_comb begin
    op_in       = op_e'(op);
    a_neg       = a_is_signed(op_in) & rs1_val[XLEN-1];
    b_neg       = b_is_signed(op_in) & rs2_val[XLEN-1];
    mag_a       = a_neg ? -rs1_val : rs1_val;
    mag_b       = b_neg ? -rs2_val : rs2_val;
    prod_next   = mplr[0] ? prod + mcand : prod;
    prod_signed = (a_neg_q ^ b_neg_q) ? -prod_next : prod_next;
  end

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] quo_next, rem_next, special;
  logic            div_zero, div_ovf;

  muldiv_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (state == IDLE && start && op[2]),
    .step     (state == CALC && op_q[2]),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Divide-by-zero and signed overflow have fixed answers and skip the iteration.
  always_comb begin
    div_zero = (rs2_val == '0);
    div_ovf  = !op[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    if (div_zero) special = op[1] ? rs1_val : '1;
    else          special = op[1] ? '0 : rs1_val;
    if (!op_q[2])     result = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    else if (op_q[1]) result = a_neg_q ? -rem_next : rem_next;
    else              result = (a_neg_q ^ b_neg_q) ? -quo_next : quo_next;
  end
`else
  assign result = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      mcand   <= '0;
      mplr    <= '0;
      prod    <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      illegal <= 1'b0;
    end else begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q    <= op_in;
          rd_q    <= rd_addr;
          a_neg_q <= a_neg;
          b_neg_q <= b_neg;
          count   <= '0;
          mcand   <= {{XLEN{1'b0}}, mag_a};
          mplr    <= mag_b;
          prod    <= '0;
          if (op[2]) begin
`ifdef MULDIV_DIV_EN
            if (div_zero || div_ovf) begin
              state   <= DONE;
              wb_we   <= 1'b1;
              wb_addr <= rd_addr;
              wb_data <= special;
            end else begin
              state <= CALC;
            end
`else
            state   <= DONE;
            wb_we   <= 1'b1;
            wb_addr <= rd_addr;
            illegal <= 1'b1;
`endif
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          count <= count + 6'd1;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          prod  <= prod_next;
          if (count == 6'(CALC_ITERS - 1)) begin
            state   <= DONE;
            count   <= '0;
            wb_we   <= 1'b1;
            wb_addr <= rd_q;
            wb_data <= result;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
// Expected divide behaviour follows MULDIV_DIV_EN as seen by this compilation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, wb_we, illegal;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: RV32M results from plain 64-bit arithmetic; lat is edges after the start edge.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] d, output logic ill, output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ill = 1'b0;
    lat = 32;
    d   = '0;
    case (o)
      3'd0: begin p = sa * sb; d = p[31:0]; end
      3'd1: begin p = sa * sb; d = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); d = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; d = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 0;
          d   = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 0;
          d   = o[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          case (o)
            3'd4:    d = 32'(sa / sb);
            3'd5:    d = a / b;
            3'd6:    d = 32'(sa % sb);
            default: d = a % b;
          endcase
        end
`else
        d   = 32'd0;
        ill = 1'b1;
        lat = 0;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit keep_start);
    logic [31:0] exp_d;
    logic        exp_ill;
    int          exp_lat, lat;
    bit          idle_bad;
    ref_model(o, a, b, exp_d, exp_ill, exp_lat);
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    op = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
    lat = -1;
    idle_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (wb_we) begin
        lat = k;
        break;
      end
      if (wb_data !== 32'd0 || wb_addr !== 5'd0) idle_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    $display("op=%0d a=%h b=%h rd=%0d -> wb_data=%h wb_addr=%0d illegal=%b latency=%0d",
             o, a, b, rd, wb_data, wb_addr, illegal, lat);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL latency op=%0d: got %0d, expected %0d", o, lat, exp_lat);
    end
    if (lat >= 0) begin
      n_vec++;
      if (wb_data !== exp_d) begin
        n_err++;
        $display("FAIL wb_data op=%0d a=%h b=%h: got %h, expected %h", o, a, b, wb_data, exp_d);
      end
      n_vec++;
      if (wb_addr !== rd) begin
        n_err++;
        $display("FAIL wb_addr: got %0d, expected %0d", wb_addr, rd);
      end
      n_vec++;
      if (illegal !== exp_ill) begin
        n_err++;
        $display("FAIL illegal op=%0d: got %b, expected %b", o, illegal, exp_ill);
      end
      n_vec++;
      if (idle_bad) begin
        n_err++;
        $display("FAIL idle_outputs: wb_data/wb_addr nonzero outside DONE, expected 0");
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (wb_we !== 1'b0 || busy !== 1'b0 || wb_data !== 32'd0) begin
        n_err++;
        $display("FAIL after_done: wb_we=%b busy=%b wb_data=%h, expected 0 0 00000000",
                 wb_we, busy, wb_data);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd6; rd_addr = 5'd3;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || wb_we !== 1'b0 || illegal !== 1'b0 || wb_data !== 32'd0 || wb_addr !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b wb_we=%b illegal=%b wb_data=%h wb_addr=%0d, expected all 0",
               busy, wb_we, illegal, wb_data, wb_addr);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    run_op(3'd5, 32'd7, 32'd0, 5'd11, 1'b0);
    run_op(3'd7, 32'd7, 32'd0, 5'd12, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_op(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd17, 1'b1);
    run_op(3'd5, 32'd1000, 32'd7, 5'd18, 1'b1);
  endtask

  task automatic test_reset_abort();
    bit saw;
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 5'd9;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'd0) begin
      n_err++;
      $display("FAIL abort_reset: busy=%b wb_we=%b wb_data=%h, expected 0 0 00000000",
               busy, wb_we, wb_data);
    end
    rst = 1'b0;
    start = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (wb_we) saw = 1'b1;
    end
    n_vec++;
    if (saw) begin
      n_err++;
      $display("FAIL abort_no_pulse: wb_we pulsed after aborting reset, expected none");
    end
    run_op(3'd0, 32'd11, 32'd13, 5'd9, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          mode;
    for (int i = 0; i < 60; i++) begin
      o    = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
      else if (mode == 3) b = 32'($urandom_range(1, 255)) | 32'hFFFF_FF00;
      run_op(o, a, b, 5'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
